// File: rtl/stream_demux2.sv
// stream_demux2 - 1-to-2 streaming demultiplexer with valid/ready handshakes.
//
// The block splits one producer stream between two consumers. Each input beat
// goes to output 0 or output 1. For a multi-beat packet, the route is locked
// from the first beat until the beat that carries in_last_i. Each output has a
// one-entry register slot. That slot can be refilled in the same cycle that it
// drains, so a consumer that is always ready sees one beat per cycle.
//
// Optional feature macro: STREAM_DEMUX2_STATS_EN
//   defined   : cnt0_o / cnt1_o count completed out0 / out1 handshakes (wrapping)
//   undefined : cnt0_o / cnt1_o are tied to 0 and no counter logic exists
//
// State table:
//   state | meaning
//   IDLE  | no packet in progress; the route comes from in_sel_i
//   LOCK0 | mid-packet, every beat goes to out0, in_sel_i ignored
//   LOCK1 | mid-packet, every beat goes to out1, in_sel_i ignored
//
// Ports:
//   clk_i, reset_n_i                 clock, async active-low reset
//   in_valid_i/in_ready_o            input handshake
//   in_data_i, in_sel_i, in_last_i   beat payload, route select, end-of-packet
//   outK_valid_o/outK_ready_i        output handshake, K = 0,1
//   outK_data_o, outK_last_o         slot contents
//   busy_o                           a packet is locked (state != IDLE)
//   cnt0_o, cnt1_o                   per-output handshake counters

module stream_demux2 #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             reset_n_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] in_data_i,
    input  logic             in_sel_i,
    input  logic             in_last_i,
    output logic             out0_valid_o,
    input  logic             out0_ready_i,
    output logic [WIDTH-1:0] out0_data_o,
    output logic             out0_last_o,
    output logic             out1_valid_o,
    input  logic             out1_ready_i,
    output logic [WIDTH-1:0] out1_data_o,
    output logic             out1_last_o,
    output logic             busy_o,
    output logic [CNT_W-1:0] cnt0_o,
    output logic [CNT_W-1:0] cnt1_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             slot0_valid_q, slot0_valid_d;
    logic [WIDTH-1:0] slot0_data_q, slot0_data_d;
    logic             slot0_last_q, slot0_last_d;
    logic             slot1_valid_q, slot1_valid_d;
    logic [WIDTH-1:0] slot1_data_q, slot1_data_d;
    logic             slot1_last_q, slot1_last_d;

    logic target;
    logic accept;
    logic hs0;
    logic hs1;

    always_comb begin
        target = in_sel_i;
        if (state_q == LOCK0) target = 1'b0;
        if (state_q == LOCK1) target = 1'b1;
    end

    // A slot can take a new beat when it is empty or is being drained in the
    // same cycle. This gives a combinational path from outK_ready_i to in_ready_o.
    assign in_ready_o = target ? (!slot1_valid_q || out1_ready_i)
                               : (!slot0_valid_q || out0_ready_i);
    assign accept     = in_valid_i && in_ready_o;
    assign hs0        = slot0_valid_q && out0_ready_i;
    assign hs1        = slot1_valid_q && out1_ready_i;

    always_comb begin
        state_d       = state_q;
        slot0_valid_d = slot0_valid_q;
        slot0_data_d  = slot0_data_q;
        slot0_last_d  = slot0_last_q;
        slot1_valid_d = slot1_valid_q;
        slot1_data_d  = slot1_data_q;
        slot1_last_d  = slot1_last_q;

        if (accept) begin
            if (state_q == IDLE) begin
                if (!in_last_i) state_d = in_sel_i ? LOCK1 : LOCK0;
            end else if (in_last_i) begin
                state_d = IDLE;
            end
        end

        // The drain is applied first. A load in the same cycle then overrides
        // it, so valid stays high and the new beat replaces the old one.
        if (hs0) slot0_valid_d = 1'b0;
        if (hs1) slot1_valid_d = 1'b0;
        if (accept && !target) begin
            slot0_valid_d = 1'b1;
            slot0_data_d  = in_data_i;
            slot0_last_d  = in_last_i;
        end
        if (accept && target) begin
            slot1_valid_d = 1'b1;
            slot1_data_d  = in_data_i;
            slot1_last_d  = in_last_i;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q       <= IDLE;
            slot0_valid_q <= 1'b0;
            slot0_data_q  <= '0;
            slot0_last_q  <= 1'b0;
            slot1_valid_q <= 1'b0;
            slot1_data_q  <= '0;
            slot1_last_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            slot0_valid_q <= slot0_valid_d;
            slot0_data_q  <= slot0_data_d;
            slot0_last_q  <= slot0_last_d;
            slot1_valid_q <= slot1_valid_d;
            slot1_data_q  <= slot1_data_d;
            slot1_last_q  <= slot1_last_d;
        end
    end

    assign out0_valid_o = slot0_valid_q;
    assign out0_data_o  = slot0_data_q;
    assign out0_last_o  = slot0_last_q;
    assign out1_valid_o = slot1_valid_q;
    assign out1_data_o  = slot1_data_q;
    assign out1_last_o  = slot1_last_q;
    assign busy_o       = (state_q != IDLE);

`ifdef STREAM_DEMUX2_STATS_EN
    logic [CNT_W-1:0] cnt0_q, cnt0_d;
    logic [CNT_W-1:0] cnt1_q, cnt1_d;

    // The counters wrap naturally at 2^CNT_W.
    always_comb begin
        cnt0_d = cnt0_q + CNT_W'(hs0);
        cnt1_d = cnt1_q + CNT_W'(hs1);
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else begin
            cnt0_q <= cnt0_d;
            cnt1_q <= cnt1_d;
        end
    end

    assign cnt0_o = cnt0_q;
    assign cnt1_o = cnt1_q;
`else
    assign cnt0_o = '0;
    assign cnt1_o = '0;
`endif

endmodule

// File: tb/tb_stream_demux2.sv
// Directed, table-driven bench for stream_demux2.
// The DUT is built with CNT_W=4 so that counter wrap can be reached quickly.
module tb_stream_demux2;

    localparam int WIDTH = 8;
    localparam int CNT_W = 4;

    logic             clk_i = 1'b0;
    logic             reset_n_i;
    logic             in_valid_i;
    logic             in_ready_o;
    logic [WIDTH-1:0] in_data_i;
    logic             in_sel_i;
    logic             in_last_i;
    logic             out0_valid_o, out0_ready_i, out0_last_o;
    logic             out1_valid_o, out1_ready_i, out1_last_o;
    logic [WIDTH-1:0] out0_data_o, out1_data_o;
    logic             busy_o;
    logic [CNT_W-1:0] cnt0_o, cnt1_o;

    always #5 clk_i = ~clk_i;

    stream_demux2 #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk_i        (clk_i),
        .reset_n_i    (reset_n_i),
        .in_valid_i   (in_valid_i),
        .in_ready_o   (in_ready_o),
        .in_data_i    (in_data_i),
        .in_sel_i     (in_sel_i),
        .in_last_i    (in_last_i),
        .out0_valid_o (out0_valid_o),
        .out0_ready_i (out0_ready_i),
        .out0_data_o  (out0_data_o),
        .out0_last_o  (out0_last_o),
        .out1_valid_o (out1_valid_o),
        .out1_ready_i (out1_ready_i),
        .out1_data_o  (out1_data_o),
        .out1_last_o  (out1_last_o),
        .busy_o       (busy_o),
        .cnt0_o       (cnt0_o),
        .cnt1_o       (cnt1_o)
    );

    typedef struct {
        logic       v;
        logic [7:0] d;
        logic       sel;
        logic       last;
        logic       r0;
        logic       r1;
        logic       e_rdy;
        logic       e_v0;
        logic [7:0] e_d0;
        logic       e_l0;
        logic       e_v1;
        logic [7:0] e_d1;
        logic       e_l1;
        logic       e_busy;
    } vec_t;

    int tests  = 0;
    int failed = 0;

    // The model tracks slot occupancy (taken from the expected table)
    // and the handshake counts that follow from it.
    logic             prev_v0 = 1'b0;
    logic             prev_v1 = 1'b0;
    logic [CNT_W-1:0] exp_c0  = '0;
    logic [CNT_W-1:0] exp_c1  = '0;

    function automatic vec_t mk(input logic v, input logic [7:0] d, input logic sel,
                                input logic last, input logic r0, input logic r1,
                                input logic e_rdy, input logic e_v0, input logic [7:0] e_d0,
                                input logic e_l0, input logic e_v1, input logic [7:0] e_d1,
                                input logic e_l1, input logic e_busy);
        vec_t t;
        t.v = v; t.d = d; t.sel = sel; t.last = last; t.r0 = r0; t.r1 = r1;
        t.e_rdy = e_rdy; t.e_v0 = e_v0; t.e_d0 = e_d0; t.e_l0 = e_l0;
        t.e_v1 = e_v1; t.e_d1 = e_d1; t.e_l1 = e_l1; t.e_busy = e_busy;
        return t;
    endfunction

    function automatic logic [CNT_W-1:0] exp_cnt(input logic [CNT_W-1:0] c);
`ifdef STREAM_DEMUX2_STATS_EN
        return c;
`else
        return (c & '0);
`endif
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input vec_t t);
        chk({tag, " out0_valid"}, 16'(out0_valid_o), 16'(t.e_v0));
        chk({tag, " out0_data"},  16'(out0_data_o),  16'(t.e_d0));
        chk({tag, " out0_last"},  16'(out0_last_o),  16'(t.e_l0));
        chk({tag, " out1_valid"}, 16'(out1_valid_o), 16'(t.e_v1));
        chk({tag, " out1_data"},  16'(out1_data_o),  16'(t.e_d1));
        chk({tag, " out1_last"},  16'(out1_last_o),  16'(t.e_l1));
        chk({tag, " busy"},       16'(busy_o),       16'(t.e_busy));
        chk({tag, " cnt0"},       16'(cnt0_o),       16'(exp_cnt(exp_c0)));
        chk({tag, " cnt1"},       16'(cnt1_o),       16'(exp_cnt(exp_c1)));
    endtask

    // Drive on the falling edge, check in_ready_o before the rising edge,
    // then check the registered outputs 1 time unit after the rising edge.
    task automatic apply(input string tag, input vec_t t);
        @(negedge clk_i);
        in_valid_i   = t.v;
        in_data_i    = t.d;
        in_sel_i     = t.sel;
        in_last_i    = t.last;
        out0_ready_i = t.r0;
        out1_ready_i = t.r1;
        #1;
        chk({tag, " in_ready"}, 16'(in_ready_o), 16'(t.e_rdy));
        if (prev_v0 && t.r0) exp_c0 = exp_c0 + 1'b1;
        if (prev_v1 && t.r1) exp_c1 = exp_c1 + 1'b1;
        @(posedge clk_i);
        #1;
        check_outs(tag, t);
        prev_v0 = t.e_v0;
        prev_v1 = t.e_v1;
    endtask

    vec_t vecs[20];
    vec_t t;

    initial begin
        //              v  d     sel last r0 r1 | rdy v0 d0    l0 v1 d1    l1 busy
        vecs[0]  = mk(0, 8'h00, 0, 0, 1, 1,   1, 0, 8'h00, 0, 0, 8'h00, 0, 0);
        vecs[1]  = mk(1, 8'hAA, 0, 1, 1, 1,   1, 1, 8'hAA, 1, 0, 8'h00, 0, 0);
        vecs[2]  = mk(1, 8'h55, 1, 1, 1, 1,   1, 0, 8'hAA, 1, 1, 8'h55, 1, 0);
        vecs[3]  = mk(0, 8'h00, 0, 0, 1, 1,   1, 0, 8'hAA, 1, 0, 8'h55, 1, 0);
        vecs[4]  = mk(1, 8'hF0, 1, 0, 1, 1,   1, 0, 8'hAA, 1, 1, 8'hF0, 0, 1);
        vecs[5]  = mk(1, 8'hF1, 0, 0, 1, 1,   1, 0, 8'hAA, 1, 1, 8'hF1, 0, 1);
        vecs[6]  = mk(1, 8'hF2, 0, 1, 1, 1,   1, 0, 8'hAA, 1, 1, 8'hF2, 1, 0);
        vecs[7]  = mk(0, 8'h00, 0, 0, 1, 1,   1, 0, 8'hAA, 1, 0, 8'hF2, 1, 0);
        vecs[8]  = mk(1, 8'h0F, 0, 1, 0, 1,   1, 1, 8'h0F, 1, 0, 8'hF2, 1, 0);
        vecs[9]  = mk(1, 8'h1E, 0, 1, 0, 1,   0, 1, 8'h0F, 1, 0, 8'hF2, 1, 0);
        vecs[10] = mk(1, 8'h1E, 0, 1, 0, 1,   0, 1, 8'h0F, 1, 0, 8'hF2, 1, 0);
        vecs[11] = mk(1, 8'h1E, 0, 1, 1, 1,   1, 1, 8'h1E, 1, 0, 8'hF2, 1, 0);
        vecs[12] = mk(0, 8'h00, 0, 0, 1, 1,   1, 0, 8'h1E, 1, 0, 8'hF2, 1, 0);
        vecs[13] = mk(1, 8'h33, 1, 1, 1, 0,   1, 0, 8'h1E, 1, 1, 8'h33, 1, 0);
        vecs[14] = mk(1, 8'hA0, 0, 0, 1, 0,   1, 1, 8'hA0, 0, 1, 8'h33, 1, 1);
        vecs[15] = mk(1, 8'hA1, 1, 0, 1, 0,   1, 1, 8'hA1, 0, 1, 8'h33, 1, 1);
        vecs[16] = mk(1, 8'hA2, 1, 0, 1, 0,   1, 1, 8'hA2, 0, 1, 8'h33, 1, 1);
        vecs[17] = mk(1, 8'hA3, 0, 1, 1, 0,   1, 1, 8'hA3, 1, 1, 8'h33, 1, 0);
        vecs[18] = mk(0, 8'h00, 1, 0, 1, 0,   0, 0, 8'hA3, 1, 1, 8'h33, 1, 0);
        vecs[19] = mk(0, 8'h00, 0, 0, 1, 1,   1, 0, 8'hA3, 1, 0, 8'h33, 1, 0);

        reset_n_i    = 1'b0;
        in_valid_i   = 1'b0;
        in_data_i    = '0;
        in_sel_i     = 1'b0;
        in_last_i    = 1'b0;
        out0_ready_i = 1'b1;
        out1_ready_i = 1'b1;
        #2;
        t = mk(0, 8'h00, 0, 0, 1, 1, 1, 0, 8'h00, 0, 0, 8'h00, 0, 0);
        chk("reset in_ready", 16'(in_ready_o), 16'd1);
        check_outs("reset", t);
        @(negedge clk_i);
        reset_n_i = 1'b1;

        for (int i = 0; i < 20; i++) apply($sformatf("vec%0d", i), vecs[i]);

        // Reset asserted mid-packet: first beat of a 3-beat packet to out1
        apply("mid_b0", mk(1, 8'hB0, 1, 0, 1, 0, 1, 0, 8'hA3, 1, 1, 8'hB0, 0, 1));
        #2;
        reset_n_i  = 1'b0;
        in_valid_i = 1'b0;
        #1;
        exp_c0  = '0;
        exp_c1  = '0;
        prev_v0 = 1'b0;
        prev_v1 = 1'b0;
        chk("mid_rst in_ready", 16'(in_ready_o), 16'd1);
        check_outs("mid_rst", mk(0, 8'h00, 0, 0, 1, 1, 1, 0, 8'h00, 0, 0, 8'h00, 0, 0));
        @(negedge clk_i);
        @(negedge clk_i);
        reset_n_i = 1'b1;

        // The next packet routes by its own select, and nothing left over appears on out1
        apply("post_c0", mk(1, 8'hC0, 0, 1, 0, 1, 1, 1, 8'hC0, 1, 0, 8'h00, 0, 0));

        // Sixteen back-to-back beats into out0 to exercise counter wrap
        for (int i = 0; i < 16; i++)
            apply($sformatf("wrap%0d", i),
                  mk(1, 8'(i + 1), 0, 1, 1, 1, 1, 1, 8'(i + 1), 1, 0, 8'h00, 0, 0));
        apply("wrap_drain", mk(0, 8'h00, 0, 0, 1, 1, 1, 0, 8'h10, 1, 0, 8'h00, 0, 0));

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
